// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg: control states, counter limits and time-bus widths
// shared by the stopwatch datapath and its tick generator.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    STOP  = 2'd0,
    RUN   = 2'd1,
    CLEAR = 2'd2
  } state_e;

  localparam int MSEC_W = 7;
  localparam int SEC_W  = 6;
  localparam int MIN_W  = 6;
  localparam int HOUR_W = 5;

  localparam logic [MSEC_W-1:0] MSEC_MAX = 7'd99;
  localparam logic [SEC_W-1:0]  SEC_MAX  = 6'd59;
  localparam logic [MIN_W-1:0]  MIN_MAX  = 6'd59;

endpackage

// File: rtl/stopwatch_datapath_tick_gen.sv
// tick_gen: divide-by-DIV counter that holds while disabled and
// emits a one-cycle tick on its last count.
module tick_gen #(
  parameter int DIV = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic clear,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick = enable && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (tick) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/stopwatch_datapath.sv
// stopwatch_datapath: STOP/RUN/CLEAR control with hh:mm:ss.cc counter chain.
// Optional lap freeze of the outputs when STOPWATCH_LAP_EN is defined.
module stopwatch_datapath
  import stopwatch_pkg::*;
#(
  parameter int CLK_FREQ = 100_000_000,
  parameter int TICK_HZ  = 100,
  parameter int HOUR_MOD = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              btn_run_stop,
  input  logic              btn_clear,
`ifdef STOPWATCH_LAP_EN
  input  logic              btn_lap,
`endif
  output logic [MSEC_W-1:0] msec,
  output logic [SEC_W-1:0]  sec,
  output logic [MIN_W-1:0]  min,
  output logic [HOUR_W-1:0] hour,
  output logic              running
);

  localparam int DIV = CLK_FREQ / TICK_HZ;
  localparam logic [HOUR_W-1:0] HOUR_MAX = HOUR_W'(HOUR_MOD - 1);

  state_e              state_q, state_d;
  logic                running_q;
  logic                tick;
  logic [MSEC_W-1:0]   msec_q, msec_d;
  logic [SEC_W-1:0]    sec_q, sec_d;
  logic [MIN_W-1:0]    min_q, min_d;
  logic [HOUR_W-1:0]   hour_q, hour_d;

  tick_gen #(
    .DIV(DIV)
  ) u_tick (
    .clk   (clk),
    .rst   (rst),
    .enable(state_q == RUN),
    .clear (state_q == CLEAR),
    .tick  (tick)
  );

  always_comb begin
    state_d = STOP;
    case (state_q)
      STOP: begin
        if (btn_clear)         state_d = CLEAR;
        else if (btn_run_stop) state_d = RUN;
        else                   state_d = STOP;
      end
      RUN:     state_d = btn_run_stop ? STOP : RUN;
      CLEAR:   state_d = STOP;
      default: state_d = STOP;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= STOP;
      running_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      running_q <= (state_d == RUN);
    end
  end

  // Carry ripples through the whole chain within one edge.
  always_comb begin
    msec_d = msec_q;
    sec_d  = sec_q;
    min_d  = min_q;
    hour_d = hour_q;
    if (state_q == CLEAR) begin
      msec_d = '0;
      sec_d  = '0;
      min_d  = '0;
      hour_d = '0;
    end else if (tick) begin
      if (msec_q == MSEC_MAX) begin
        msec_d = '0;
        if (sec_q == SEC_MAX) begin
          sec_d = '0;
          if (min_q == MIN_MAX) begin
            min_d = '0;
            if (hour_q == HOUR_MAX) hour_d = '0;
            else                    hour_d = hour_q + 1'b1;
          end else begin
            min_d = min_q + 1'b1;
          end
        end else begin
          sec_d = sec_q + 1'b1;
        end
      end else begin
        msec_d = msec_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      msec_q <= '0;
      sec_q  <= '0;
      min_q  <= '0;
      hour_q <= '0;
    end else begin
      msec_q <= msec_d;
      sec_q  <= sec_d;
      min_q  <= min_d;
      hour_q <= hour_d;
    end
  end

  assign running = running_q;

`ifdef STOPWATCH_LAP_EN
  logic                frz_q;
  logic [MSEC_W-1:0]   lap_msec_q;
  logic [SEC_W-1:0]    lap_sec_q;
  logic [MIN_W-1:0]    lap_min_q;
  logic [HOUR_W-1:0]   lap_hour_q;

  // Snapshot holds pre-edge live values; leaving RUN drops the freeze.
  always_ff @(posedge clk) begin
    if (rst || state_q == CLEAR) begin
      frz_q      <= 1'b0;
      lap_msec_q <= '0;
      lap_sec_q  <= '0;
      lap_min_q  <= '0;
      lap_hour_q <= '0;
    end else if (state_d != RUN) begin
      frz_q <= 1'b0;
    end else if (state_q == RUN && btn_lap) begin
      frz_q <= ~frz_q;
      if (!frz_q) begin
        lap_msec_q <= msec_q;
        lap_sec_q  <= sec_q;
        lap_min_q  <= min_q;
        lap_hour_q <= hour_q;
      end
    end
  end

  assign msec = frz_q ? lap_msec_q : msec_q;
  assign sec  = frz_q ? lap_sec_q  : sec_q;
  assign min  = frz_q ? lap_min_q  : min_q;
  assign hour = frz_q ? lap_hour_q : hour_q;
`else
  assign msec = msec_q;
  assign sec  = sec_q;
  assign min  = min_q;
  assign hour = hour_q;
`endif

endmodule

// File: tb/tb_stopwatch_datapath.sv
// tb_stopwatch_datapath: directed scoreboard bench, DIV=10 build.
// Lap steps are included when STOPWATCH_LAP_EN is defined.
module tb_stopwatch_datapath;

  logic       clk = 1'b0;
  logic       rst;
  logic       brs;
  logic       bcl;
`ifdef STOPWATCH_LAP_EN
  logic       lap;
`endif
  logic [6:0] msec;
  logic [5:0] sec;
  logic [5:0] min;
  logic [4:0] hour;
  logic       running;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       tag;
    logic [24:0] val;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  stopwatch_datapath #(
    .CLK_FREQ(1000),
    .TICK_HZ (100),
    .HOUR_MOD(24)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .btn_run_stop(brs),
    .btn_clear   (bcl),
`ifdef STOPWATCH_LAP_EN
    .btn_lap     (lap),
`endif
    .msec        (msec),
    .sec         (sec),
    .min         (min),
    .hour        (hour),
    .running     (running)
  );

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input string tag, input int h, input int mi,
                      input int s, input int ms, input int r);
    exp_t e;
    e.tag = tag;
    e.val = {5'(h), 6'(mi), 6'(s), 7'(ms), 1'(r)};
    sb.push_back(e);
  endtask

  task automatic chk();
    exp_t        e;
    logic [24:0] obs;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty obs=none exp=entry");
    end else begin
      e   = sb.pop_front();
      obs = {hour, min, sec, msec, running};
      assert (obs === e.val) else begin
        errors++;
        $error("FAIL %s obs=%0d:%0d:%0d.%0d run=%0d exp=%0d:%0d:%0d.%0d run=%0d",
               e.tag, obs[24:20], obs[19:14], obs[13:8], obs[7:1], obs[0],
               e.val[24:20], e.val[19:14], e.val[13:8], e.val[7:1], e.val[0]);
      end
    end
  endtask

  task automatic chk_div(input string tag, input int exp_v);
    logic [3:0] d;
    logic [3:0] x;
    d = dut.u_tick.cnt_q;
    x = 4'(exp_v);
    checks++;
    assert (d === x) else begin
      errors++;
      $error("FAIL %s divider obs=%0d exp=%0d", tag, d, x);
    end
  endtask

  task automatic preload(input int h);
    force dut.msec_q = 7'd99;
    force dut.sec_q  = 6'd59;
    force dut.min_q  = 6'd59;
    force dut.hour_q = 5'(h);
    force dut.u_tick.cnt_q = 4'd9;
    #1;
    release dut.msec_q;
    release dut.sec_q;
    release dut.min_q;
    release dut.hour_q;
    release dut.u_tick.cnt_q;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL timeout obs=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    brs = 1'b0;
    bcl = 1'b0;
`ifdef STOPWATCH_LAP_EN
    lap = 1'b0;
`endif
    cyc(3);
    push("reset", 0, 0, 0, 0, 0); chk();
    chk_div("reset_div", 0);
    rst = 1'b0;
    push("idle_no_run", 0, 0, 0, 0, 0); cyc(5); chk();

    brs = 1'b1; push("run_enter", 0, 0, 0, 0, 1);
    cyc(1); brs = 1'b0; chk();
    chk_div("enter_div", 0);
    push("first_tick_pre", 0, 0, 0, 0, 1); cyc(9); chk();
    chk_div("pre_tick_div", 9);
    push("msec_1", 0, 0, 0, 1, 1); cyc(1); chk();
    push("msec_50", 0, 0, 0, 50, 1); cyc(490); chk();
    push("msec_99", 0, 0, 0, 99, 1); cyc(499); chk();
    push("sec_carry", 0, 0, 1, 0, 1); cyc(1); chk();

    cyc(425);
    brs = 1'b1; push("stop", 0, 0, 1, 42, 0);
    cyc(1); brs = 1'b0; chk();
    chk_div("stop_div", 6);
    push("stop_hold", 0, 0, 1, 42, 0); cyc(200); chk();
    chk_div("hold_div", 6);
    brs = 1'b1; push("resume", 0, 0, 1, 42, 1);
    cyc(1); brs = 1'b0; chk();
    push("resume_3", 0, 0, 1, 42, 1); cyc(3); chk();
    chk_div("resume_div", 9);
    push("resume_4", 0, 0, 1, 43, 1); cyc(1); chk();

    push("at_5_37", 0, 0, 5, 37, 1); cyc(3940); chk();
    rst = 1'b1; push("rst_mid_run", 0, 0, 0, 0, 0);
    cyc(1); chk();
    cyc(1); rst = 1'b0;
    push("rst_no_count", 0, 0, 0, 0, 0); cyc(20); chk();
    chk_div("rst_div", 0);

    brs = 1'b1; cyc(1); brs = 1'b0;
    cyc(62034);
    brs = 1'b1; push("stop_1m", 0, 1, 2, 3, 0);
    cyc(1); brs = 1'b0; chk();
    chk_div("stop_1m_div", 5);
    brs = 1'b1; bcl = 1'b1; push("clear_cycle", 0, 1, 2, 3, 0);
    cyc(1); bcl = 1'b0; chk();
    push("clear_done", 0, 0, 0, 0, 0);
    cyc(1); brs = 1'b0; chk();
    chk_div("clear_div", 0);
    push("clear_stays_stop", 0, 0, 0, 0, 0); cyc(10); chk();

    brs = 1'b1; push("run2", 0, 0, 0, 0, 1);
    cyc(1); brs = 1'b0; chk();
    cyc(15);
    bcl = 1'b1; push("clear_in_run", 0, 0, 0, 1, 1);
    cyc(1); bcl = 1'b0; chk();
    chk_div("clear_in_run_div", 6);
    push("clear_in_run_cont", 0, 0, 0, 2, 1); cyc(4); chk();

    preload(0);
    push("preload_0", 0, 59, 59, 99, 1); chk();
    push("hour_carry", 1, 0, 0, 0, 1); cyc(1); chk();
    preload(23);
    push("preload_23", 23, 59, 59, 99, 1); chk();
    push("full_rollover", 0, 0, 0, 0, 1); cyc(1); chk();
    push("after_rollover", 0, 0, 0, 1, 1); cyc(10); chk();

`ifdef STOPWATCH_LAP_EN
    brs = 1'b1; cyc(1); brs = 1'b0;
    bcl = 1'b1; cyc(1); bcl = 1'b0;
    cyc(1);
    brs = 1'b1; cyc(1); brs = 1'b0;
    cyc(1200);
    lap = 1'b1; push("lap_snap", 0, 0, 1, 20, 1);
    cyc(1); lap = 1'b0; chk();
    push("lap_hold", 0, 0, 1, 20, 1); cyc(299); chk();
    lap = 1'b1; push("lap_release", 0, 0, 1, 50, 1);
    cyc(1); lap = 1'b0; chk();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
